// File: rtl/sm83_fetch_queue.sv
// SM83 instruction prefetch queue: single-outstanding memory fetcher feeding a DEPTH-entry byte FIFO.
// Optional FETCHQ_BYPASS_EN: presents a returning byte combinationally when the queue is empty.
module sm83_fetch_queue #(
    parameter int                DEPTH    = 4,
    parameter int                ADDR_W   = 16,
    parameter int                DATA_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    output logic                       mem_req,
    output logic [ADDR_W-1:0]          mem_addr,
    input  logic                       mem_ack,
    input  logic [DATA_W-1:0]          mem_rdata,
    input  logic                       redirect,
    input  logic [ADDR_W-1:0]          redirect_pc,
    input  logic                       deq,
    output logic                       q_valid,
    output logic [DATA_W-1:0]          q_data,
    output logic [ADDR_W-1:0]          q_pc,
    output logic [$clog2(DEPTH):0]     q_count,
    output logic [1:0]                 dbg_state
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // Handshake: a fetch is outstanding while mem_req=1; mem_ack=1 completes it in that same
    // cycle with mem_rdata valid, and mem_addr stays put until then.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] fetch_pc, fetch_pc_nx;
    logic [ADDR_W-1:0] drop_pc, drop_pc_nx;
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count, count_nx;
    logic              valid_r;
    logic              ack_in_req, bypass_hit, push, pop;

    assign ack_in_req = (state == REQ) && mem_ack;

`ifdef FETCHQ_BYPASS_EN
    assign bypass_hit = ack_in_req && !redirect && (count == '0);
`else
    assign bypass_hit = 1'b0;
`endif

    // Redirect wins over both queue operations; a bypassed byte taken by deq never enters the queue.
    assign pop  = deq && valid_r && !redirect;
    assign push = ack_in_req && !redirect && !(bypass_hit && deq);

    always_comb begin
        count_nx = count;
        if (redirect)
            count_nx = '0;
        else if (push && !pop)
            count_nx = count + 1'b1;
        else if (pop && !push)
            count_nx = count - 1'b1;
    end

    always_comb begin
        state_nx    = state;
        fetch_pc_nx = fetch_pc;
        drop_pc_nx  = drop_pc;
        case (state)
            IDLE: begin
                if (redirect)
                    fetch_pc_nx = redirect_pc;
                else if (count_nx < DEPTH_C)
                    state_nx = REQ;
            end
            REQ: begin
                if (redirect) begin
                    fetch_pc_nx = redirect_pc;
                    if (mem_ack) begin
                        state_nx = IDLE;
                    end else begin
                        // Memory still owes us the stale byte: park its address and swallow it.
                        drop_pc_nx = fetch_pc;
                        state_nx   = DROP;
                    end
                end else if (mem_ack) begin
                    fetch_pc_nx = fetch_pc + 1'b1;
                    if (!(count_nx < DEPTH_C))
                        state_nx = IDLE;
                end
            end
            DROP: begin
                if (redirect)
                    fetch_pc_nx = redirect_pc;
                if (mem_ack)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            drop_pc  <= RESET_PC;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            valid_r  <= 1'b0;
        end else begin
            state    <= state_nx;
            fetch_pc <= fetch_pc_nx;
            drop_pc  <= drop_pc_nx;
            count    <= count_nx;
            valid_r  <= (count_nx != '0);
            if (redirect) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + 1'b1;
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr] <= mem_rdata;
            pc_mem[wr_ptr]   <= fetch_pc;
        end
    end

    assign mem_req   = (state != IDLE);
    assign mem_addr  = (state == DROP) ? drop_pc : fetch_pc;
    assign q_valid   = valid_r | bypass_hit;
    assign q_data    = bypass_hit ? mem_rdata : data_mem[rd_ptr];
    assign q_pc      = bypass_hit ? fetch_pc : pc_mem[rd_ptr];
    assign q_count   = count;
    assign dbg_state = state;

endmodule

// File: tb/tb_sm83_fetch_queue.sv
// Bench for sm83_fetch_queue: directed scenarios plus a randomized run against a byte-stream scoreboard.
// Build with FETCHQ_BYPASS_EN defined to exercise the bypass variant.
module tb_sm83_fetch_queue;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              deq;
    logic              q_valid;
    logic [DATA_W-1:0] q_data;
    logic [ADDR_W-1:0] q_pc;
    logic [2:0]        q_count;
    logic [1:0]        dbg_state;

    int checks = 0;
    int errors = 0;
    logic [23:0] exp_q[$];
    logic [15:0] exp_pc;

    always #5 clk = ~clk;

    sm83_fetch_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_PC(16'h0000)) dut (
        .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .redirect(redirect), .redirect_pc(redirect_pc), .deq(deq),
        .q_valid(q_valid), .q_data(q_data), .q_pc(q_pc), .q_count(q_count), .dbg_state(dbg_state)
    );

    // Memory contents as a pure function of address.
    function automatic logic [7:0] mem_fn(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    task automatic drive_idle();
        mem_ack = 1'b0; mem_rdata = '0; redirect = 1'b0; redirect_pc = '0; deq = 1'b0;
    endtask

    task automatic test_reset();
        logic [15:0] seen[$];
        drive_idle();
        rst_n = 1'b0;
        mem_ack = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %b want 0", mem_req); end
        checks++; if (q_valid !== 1'b0) begin errors++; $display("FAIL reset_q_valid got %b want 0", q_valid); end
        checks++; if (q_count !== 3'd0) begin errors++; $display("FAIL reset_q_count got %0d want 0", q_count); end
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            mem_rdata = mem_fn(mem_addr);
            @(negedge clk);
            if (c == 0) begin
                checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0000) begin
                    errors++; $display("FAIL first_req got req=%b addr=%h want req=1 addr=0000", mem_req, mem_addr); end
`ifndef FETCHQ_BYPASS_EN
                checks++; if (q_valid !== 1'b0) begin errors++; $display("FAIL no_early_valid got %b want 0", q_valid); end
`endif
            end
            if (mem_req && mem_ack) seen.push_back(mem_addr);
        end
        checks++; if (seen.size() != 4) begin errors++; $display("FAIL fill_ack_count got %0d want 4", seen.size()); end
        for (int i = 0; i < seen.size(); i++) begin
            checks++; if (seen[i] !== 16'(i)) begin errors++; $display("FAIL fill_addr[%0d] got %h want %h", i, seen[i], 16'(i)); end
        end
        checks++; if (q_count !== 3'd4) begin errors++; $display("FAIL fill_q_count got %0d want 4", q_count); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL fill_mem_req got %b want 0", mem_req); end
        checks++; if (q_pc !== 16'h0000 || q_data !== mem_fn(16'h0000)) begin
            errors++; $display("FAIL fill_head got pc=%h data=%h want pc=0000 data=%h", q_pc, q_data, mem_fn(16'h0000)); end
        mem_ack = 1'b0;
    endtask

    task automatic test_full_stream();
        exp_pc = 16'h0000;
        for (int c = 0; c < 16; c++) begin
            @(posedge clk); #1;
            deq = 1'b1; mem_ack = 1'b1; mem_rdata = mem_fn(mem_addr);
            @(negedge clk);
            checks++; if (q_valid !== 1'b1 || q_pc !== exp_pc || q_data !== mem_fn(exp_pc)) begin
                errors++; $display("FAIL stream_head got v=%b pc=%h d=%h want v=1 pc=%h d=%h", q_valid, q_pc, q_data, exp_pc, mem_fn(exp_pc)); end
            checks++; if (q_count !== 3'd3 && q_count !== 3'd4) begin
                errors++; $display("FAIL stream_count got %0d want 3 or 4", q_count); end
            exp_pc = exp_pc + 16'd1;
        end
        deq = 1'b0; mem_ack = 1'b0;
    endtask

    task automatic test_redirect_drop();
        logic found;
        @(posedge clk); #1;
        redirect = 1'b1; redirect_pc = 16'h0102; mem_ack = 1'b0;
        @(posedge clk); #1;
        redirect = 1'b0; found = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (mem_req && mem_addr == 16'h0102) begin found = 1'b1; break; end
            mem_ack = mem_req; mem_rdata = 8'h55;
            @(posedge clk); #1;
        end
        mem_ack = 1'b0;
        checks++; if (!found) begin errors++; $display("FAIL drop_reach_req got none want addr 0102"); end
        redirect = 1'b1; redirect_pc = 16'h0200;
        @(posedge clk); #1;
        redirect = 1'b0;
        @(negedge clk);
        checks++; if (q_count !== 3'd0) begin errors++; $display("FAIL drop_flush got %0d want 0", q_count); end
        checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0102) begin
            errors++; $display("FAIL drop_stale_addr got req=%b addr=%h want req=1 addr=0102", mem_req, mem_addr); end
        @(posedge clk); #1;
        @(posedge clk); #1;
        mem_ack = 1'b1; mem_rdata = 8'hAA;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (mem_req) begin found = 1'b1; break; end
        end
        checks++; if (!found || mem_addr !== 16'h0200) begin
            errors++; $display("FAIL drop_next_req got found=%b addr=%h want addr 0200", found, mem_addr); end
        checks++; if (q_count !== 3'd0 || q_valid !== 1'b0) begin
            errors++; $display("FAIL drop_discard got count=%0d v=%b want 0 0", q_count, q_valid); end
    endtask

    task automatic test_redirect_ack();
        @(posedge clk); #1;
        redirect = 1'b1; redirect_pc = 16'h0300; mem_ack = 1'b1; mem_rdata = 8'h77; deq = 1'b1;
        @(posedge clk); #1;
        drive_idle();
        @(negedge clk);
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL redir_ack_idle got req=%b want 0", mem_req); end
        checks++; if (q_count !== 3'd0 || q_valid !== 1'b0) begin
            errors++; $display("FAIL redir_ack_discard got count=%0d v=%b want 0 0", q_count, q_valid); end
        @(negedge clk);
        checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0300) begin
            errors++; $display("FAIL redir_ack_next got req=%b addr=%h want req=1 addr=0300", mem_req, mem_addr); end
    endtask

    task automatic test_wrap();
        logic [15:0] e;
        @(posedge clk); #1;
        redirect = 1'b1; redirect_pc = 16'hFFFE; mem_ack = 1'b1; mem_rdata = mem_fn(mem_addr);
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            redirect = 1'b0; mem_ack = 1'b1; mem_rdata = mem_fn(mem_addr);
        end
        @(negedge clk);
        mem_ack = 1'b0;
        checks++; if (q_count !== 3'd4) begin errors++; $display("FAIL wrap_fill got %0d want 4", q_count); end
        for (int i = 0; i < 4; i++) begin
            e = 16'hFFFE + 16'(i);
            @(posedge clk); #1;
            deq = 1'b1;
            @(negedge clk);
            checks++; if (q_pc !== e || q_data !== mem_fn(e)) begin
                errors++; $display("FAIL wrap_seq[%0d] got pc=%h d=%h want pc=%h d=%h", i, q_pc, q_data, e, mem_fn(e)); end
        end
        deq = 1'b0;
    endtask

    task automatic test_bypass();
        logic found;
        @(posedge clk); #1;
        redirect = 1'b1; redirect_pc = 16'h0400; mem_ack = 1'b0; deq = 1'b0;
        @(posedge clk); #1;
        redirect = 1'b0; found = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (mem_req && mem_addr == 16'h0400) begin found = 1'b1; break; end
            mem_ack = mem_req; mem_rdata = 8'h11;
            @(posedge clk); #1;
        end
        checks++; if (!found) begin errors++; $display("FAIL bypass_reach_req got none want addr 0400"); end
        mem_ack = 1'b1; mem_rdata = 8'h3E; deq = 1'b1;
        @(negedge clk);
`ifdef FETCHQ_BYPASS_EN
        checks++; if (q_valid !== 1'b1 || q_data !== 8'h3E || q_pc !== 16'h0400) begin
            errors++; $display("FAIL bypass_same_cycle got v=%b d=%h pc=%h want 1 3e 0400", q_valid, q_data, q_pc); end
        @(posedge clk); #1;
        drive_idle();
        @(negedge clk);
        checks++; if (q_count !== 3'd0 || q_valid !== 1'b0) begin
            errors++; $display("FAIL bypass_consumed got count=%0d v=%b want 0 0", q_count, q_valid); end
`else
        checks++; if (q_valid !== 1'b0) begin errors++; $display("FAIL queued_same_cycle got v=%b want 0", q_valid); end
        @(posedge clk); #1;
        drive_idle();
        @(negedge clk);
        checks++; if (q_count !== 3'd1 || q_valid !== 1'b1 || q_data !== 8'h3E || q_pc !== 16'h0400) begin
            errors++; $display("FAIL queued_next got count=%0d v=%b d=%h pc=%h want 1 1 3e 0400", q_count, q_valid, q_data, q_pc); end
`endif
    endtask

    task automatic test_reset_abandon();
        @(negedge clk);
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL abandon_outstanding got req=%b want 1", mem_req); end
        rst_n = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0 || q_count !== 3'd0 || q_valid !== 1'b0) begin
            errors++; $display("FAIL async_reset got req=%b count=%0d v=%b want 0 0 0", mem_req, q_count, q_valid); end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1; mem_ack = 1'b1; mem_rdata = 8'hEE;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        @(negedge clk);
        checks++; if (q_count !== 3'd0 || mem_req !== 1'b1 || mem_addr !== 16'h0000) begin
            errors++; $display("FAIL late_ack got count=%0d req=%b addr=%h want 0 1 0000", q_count, mem_req, mem_addr); end
        @(posedge clk); #1;
        mem_ack = 1'b1; mem_rdata = mem_fn(mem_addr);
        @(posedge clk); #1;
        mem_ack = 1'b0;
        @(negedge clk);
        checks++; if (q_count !== 3'd1 || q_pc !== 16'h0000 || q_data !== mem_fn(16'h0000)) begin
            errors++; $display("FAIL post_reset_fetch got count=%0d pc=%h d=%h want 1 0000 %h", q_count, q_pc, q_data, mem_fn(16'h0000)); end
    endtask

    task automatic test_random();
        logic        prev_req, prev_ack, flushed;
        logic [15:0] prev_addr;
        logic [23:0] e;
        int          ndeq;
        prev_req = 1'b0; prev_ack = 1'b0; flushed = 1'b0; prev_addr = '0; ndeq = 0;
        exp_q.delete();
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            if (prev_req && !prev_ack) begin
                checks++; if (mem_addr !== prev_addr) begin
                    errors++; $display("FAIL addr_stable got %h want %h", mem_addr, prev_addr); end
            end
            if (flushed) begin
                checks++; if (q_count !== 3'd0) begin errors++; $display("FAIL redirect_flush got %0d want 0", q_count); end
            end
            redirect    = (c == 0) || ($urandom_range(0, 39) == 0);
            redirect_pc = 16'($urandom);
            mem_ack     = mem_req && ($urandom_range(0, 3) != 0);
            mem_rdata   = mem_ack ? mem_fn(mem_addr) : 8'($urandom);
            deq         = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            checks++; if (q_count > 3'(DEPTH)) begin errors++; $display("FAIL count_bound got %0d want <= %0d", q_count, DEPTH); end
`ifdef FETCHQ_BYPASS_EN
            checks++; if (q_count != 3'd0 && q_valid !== 1'b1) begin
                errors++; $display("FAIL valid_vs_count got v=%b count=%0d want v=1", q_valid, q_count); end
`else
            checks++; if (q_valid !== (q_count != 3'd0)) begin
                errors++; $display("FAIL valid_vs_count got v=%b count=%0d want v=%b", q_valid, q_count, q_count != 3'd0); end
`endif
            if (redirect) begin
                exp_q.delete();
                exp_pc = redirect_pc;
            end else if (deq && q_valid) begin
                if (exp_q.size() == 0) begin
                    exp_q.push_back({exp_pc, mem_fn(exp_pc)});
                    exp_pc = exp_pc + 16'd1;
                end
                e = exp_q.pop_front();
                ndeq++;
                checks++; if ({q_pc, q_data} !== e) begin
                    errors++; $display("FAIL stream_byte got pc=%h d=%h want pc=%h d=%h", q_pc, q_data, e[23:8], e[7:0]); end
            end
            flushed = redirect; prev_req = mem_req; prev_ack = mem_ack; prev_addr = mem_addr;
        end
        drive_idle();
        checks++; if (ndeq < 500) begin errors++; $display("FAIL throughput got %0d dequeues want >= 500", ndeq); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        drive_idle();
        rst_n = 1'b0;
        test_reset();
        test_full_stream();
        test_redirect_drop();
        test_redirect_ack();
        test_wrap();
        test_bypass();
        test_reset_abandon();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
